// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache that
// sits between the MEM-stage load/store path and DataMemory. Line refill reads
// DataMemory's combinational port one word per cycle while the pipeline stalls.
// Optional load hit/miss statistics are built only when DCACHE_STATS_EN is defined.
module data_cache #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 32,
    parameter int BLOCK_WORDS   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    input  logic                     cpu_we,
    input  logic                     cpu_re,
    input  logic                     cpu_byte,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     stall,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     mem_we,
    output logic                     mem_byte,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);
    localparam int OFF_W  = $clog2(4 * BLOCK_WORDS);
    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDRESS_WIDTH - IDX_W - OFF_W;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                  state, state_nxt;
    logic [WORD_W-1:0]       cnt;
    logic [SETS-1:0]         valid;
    logic [TAG_W-1:0]        tag_ram  [SETS];
    logic [DATA_WIDTH-1:0]   data_ram [SETS*BLOCK_WORDS];

    logic [TAG_W-1:0]        tag;
    logic [IDX_W-1:0]        idx;
    logic [WORD_W-1:0]       woff;
    logic [1:0]              lane;
    logic                    misaligned;
    logic                    hit;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    ld_hit, ld_miss, st_hit, refill_wr, refill_done;

    assign tag        = cpu_addr[ADDRESS_WIDTH-1 -: TAG_W];
    assign idx        = cpu_addr[OFF_W +: IDX_W];
    assign woff       = cpu_addr[2 +: WORD_W];
    assign lane       = cpu_addr[1:0];
    assign misaligned = !cpu_byte && (lane != 2'b00);
    assign hit        = valid[idx] && (tag_ram[idx] == tag);
    assign rd_word    = data_ram[{idx, woff}];

    // Load data: misaligned word accesses bypass the array; byte loads zero-extend
    always_comb begin
        cpu_rdata = rd_word;
        if (misaligned)
            cpu_rdata = mem_rdata;
        else if (cpu_byte)
            cpu_rdata = {{(DATA_WIDTH-8){1'b0}}, rd_word[{lane, 3'b000} +: 8]};
    end

    // Next-state, stall and memory-side drive; outputs are quiet while in reset
    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        mem_addr    = cpu_addr;
        mem_wdata   = cpu_wdata;
        mem_we      = cpu_we;
        mem_byte    = cpu_byte;
        ld_hit      = 1'b0;
        ld_miss     = 1'b0;
        st_hit      = 1'b0;
        refill_wr   = 1'b0;
        refill_done = 1'b0;
        case (state)
            IDLE: begin
                if (!misaligned) begin
                    if (cpu_we) begin
                        st_hit = hit;
                    end else if (cpu_re) begin
                        if (hit) begin
                            ld_hit = 1'b1;
                        end else begin
                            ld_miss   = 1'b1;
                            stall     = 1'b1;
                            state_nxt = REFILL;
                        end
                    end
                end
            end
            REFILL: begin
                mem_addr  = {tag, idx, cnt, 2'b00};
                mem_we    = 1'b0;
                mem_byte  = 1'b0;
                stall     = 1'b1;
                refill_wr = 1'b1;
                if (cnt == LAST_WORD) begin
                    refill_done = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst_n) begin
            stall  = 1'b0;
            mem_we = 1'b0;
        end
    end

    // Control state: FSM, refill word counter and valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= '0;
        end else begin
            state <= state_nxt;
            if (ld_miss) begin
                // Line is invalid while it is being overwritten word by word
                cnt        <= '0;
                valid[idx] <= 1'b0;
            end else if (refill_wr) begin
                cnt <= cnt + WORD_W'(1);
            end
            if (refill_done)
                valid[idx] <= 1'b1;
        end
    end

    // Tag and data arrays: refill words, store-hit updates, tag on refill completion
    always_ff @(posedge clk) begin
        if (refill_wr)
            data_ram[{idx, cnt}] <= mem_rdata;
        else if (st_hit && cpu_byte)
            data_ram[{idx, woff}][{lane, 3'b000} +: 8] <= cpu_wdata[7:0];
        else if (st_hit)
            data_ram[{idx, woff}] <= cpu_wdata;
        if (refill_done)
            tag_ram[idx] <= tag;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_q, miss_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating load hit/miss statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (ld_hit)
                hit_q <= sat_inc(hit_q);
            if (ld_miss)
                miss_q <= sat_inc(miss_q);
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed test of data_cache against a small DataMemory model.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_we, cpu_re, cpu_byte, stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_byte;
    logic [31:0] hit_count, miss_count;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb [$];
    logic        mem_init;
    logic [31:0] mem [4096];

    always #5 clk = ~clk;

    data_cache dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_re(cpu_re), .cpu_byte(cpu_byte), .cpu_rdata(cpu_rdata),
        .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_byte(mem_byte), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    function automatic logic [31:0] pat(input int i);
        logic [11:0] w;
        w = i[11:0];
        return (i == 0) ? 32'hDEAD_BEEF : {16'hC0DE, 4'h0, w};
    endfunction

    // DataMemory model: combinational read, byte/word write on the clock edge
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
        end else if (mem_we) begin
            if (mem_byte) mem[mem_addr[13:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
            else          mem[mem_addr[13:2]] <= mem_wdata;
        end
    end

    always_comb begin
        mem_rdata = mem[mem_addr[13:2]];
        if (mem_byte) mem_rdata = {24'b0, mem[mem_addr[13:2]][{mem_addr[1:0], 3'b000} +: 8]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a load, count stall cycles (bounded), compare data against the scoreboard
    task automatic do_load(input string tag, input logic [31:0] a, input logic b,
                           input int exp_stalls, input logic [31:0] exp);
        int n;
        sb.push_back(exp);
        cpu_addr = a; cpu_byte = b; cpu_we = 1'b0; cpu_re = 1'b1;
        n = 0;
        @(negedge clk);
        while (stall === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_stalls"}, n, exp_stalls);
        check({tag, "_data"}, cpu_rdata, sb.pop_front());
        @(posedge clk); #1;
        cpu_re = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d, input logic b);
        cpu_addr = a; cpu_wdata = d; cpu_byte = b; cpu_re = 1'b0; cpu_we = 1'b1;
        @(negedge clk);
        check({tag, "_mem_we"}, mem_we, 1);
        check({tag, "_mem_byte"}, mem_byte, b);
        check({tag, "_mem_addr"}, mem_addr, a);
        check({tag, "_stall"}, stall, 0);
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mem_init = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_byte = 1'b0;
        repeat (3) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_load("cold_miss", 32'h0001_0000, 1'b0, 5, 32'hDEAD_BEEF);
        do_load("line_hit", 32'h0001_000C, 1'b0, 0, pat(3));
        do_store("st_byte", 32'h0001_0001, 32'h0000_00A5, 1'b1);
        do_load("after_st_byte", 32'h0001_0000, 1'b0, 0, 32'hDEAD_A5EF);
        do_load("byte_load", 32'h0001_0001, 1'b1, 0, 32'h0000_00A5);
        do_store("st_nalloc", 32'h0001_0400, 32'h1234_5678, 1'b0);
        do_load("no_alloc_miss", 32'h0001_0400, 1'b0, 5, 32'h1234_5678);
        do_load("fill_conflict", 32'h0001_1000, 1'b0, 5, pat(32'h400));
        do_load("conflict_miss", 32'h0001_0000, 1'b0, 5, 32'hDEAD_A5EF);
        do_load("misaligned", 32'h0001_0402, 1'b0, 0, 32'h1234_5678);

        cpu_addr = 32'h0001_0808;
        @(negedge clk);
        check("idle_mem_addr", mem_addr, 32'h0001_0808);
        check("idle_mem_we", mem_we, 0);
        check("idle_stall", stall, 0);
`ifdef DCACHE_STATS_EN
        check("stats_hits", hit_count, 7);
        check("stats_misses", miss_count, 4);
`else
        check("stats_hits_off", hit_count, 0);
        check("stats_misses_off", miss_count, 0);
`endif
        @(posedge clk); #1;

        // Reset in the second REFILL cycle
        cpu_addr = 32'h0002_0010; cpu_byte = 1'b0; cpu_re = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_refill_stall", stall, 0);
        check("rst_refill_mem_we", mem_we, 0);
        check("rst_refill_hits", hit_count, 0);
        check("rst_refill_misses", miss_count, 0);
        cpu_re = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_load("reissue_miss", 32'h0002_0010, 1'b0, 5, pat(4));
`ifdef DCACHE_STATS_EN
        @(negedge clk);
        check("reissue_misses", miss_count, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
